// File: rtl/ycbcr_pkg.sv
// Shared constants for the RGB to YCbCr stream converter.
// Mode codes, coefficient sets, offset and clip helpers.
package ycbcr_pkg;

  localparam logic [1:0] MODE_601    = 2'd0;
  localparam logic [1:0] MODE_709    = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  // Order: Yr Yg Yb, Cbr Cbg Cbb, Crr Crg Crb
  localparam int COEF_601 [9] = '{
    77, 150, 29,
    -43, -85, 128,
    128, -107, -21
  };

  localparam int COEF_709 [9] = '{
    54, 183, 19,
    -29, -99, 128,
    128, -116, -12
  };

  // Reserved code 3 falls back to BT.601
  function automatic logic [1:0] norm_mode(
    input logic [1:0] m
  );
    return (m == 2'd3) ? MODE_601 : m;
  endfunction

  // Offsets are pre-scaled by the 8 coefficient fraction bits
  function automatic int y_offset(input int w);
    return 16 << w;
  endfunction

  function automatic int c_offset(input int w);
    return 1 << (w + 7);
  endfunction

  function automatic int clip(
    input int v,
    input int w
  );
    if (v < 0) return 0;
    if (v > (1 << w) - 1) return (1 << w) - 1;
    return v;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO: push/din in, pop/dout/valid out.
// count reports occupancy; pushes while full are ignored.
module axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr;
  logic [PW-1:0]    rd;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != (PW+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (do_pop)
        rd <= rd + 1'b1;
      cnt <= cnt + (PW+1)'(do_push)
                 - (PW+1)'(do_pop);
    end
  end

  assign dout  = mem[rd];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/ycbcr_stream_conv.sv
// AXI4-Stream RGB {R,B,G} to YCbCr {Cr,Cb,Y} converter.
// Matrix latched on SOF (tuser); products, sum/clip, output FIFO.
module ycbcr_stream_conv
  import ycbcr_pkg::*;
#(
  parameter int COMP_W     = 8,
  parameter int COEF_FRAC  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Sel,
  input  logic [3*COMP_W-1:0]   Sel_RGB,
  input  logic [1:0]            mode,
  input  logic [3*COMP_W-1:0]   s_axis_video_tdata,
  input  logic                  s_axis_video_tvalid,
  output logic                  s_axis_video_tready,
  input  logic                  s_axis_video_tlast,
  input  logic                  s_axis_video_tuser,
  output logic [3*COMP_W-1:0]   m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tlast,
  output logic                  m_axis_video_tuser,
  output logic [1:0]            active_mode
);

  localparam int DW = 3 * COMP_W;
  localparam int AW = COMP_W + 11;
  localparam int FW = DW + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = CW + 2;

  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t RND   = acc_t'(1 << (COEF_FRAC - 1));
  localparam acc_t Y_OFS = acc_t'(y_offset(COMP_W));
  localparam acc_t C_OFS = acc_t'(c_offset(COMP_W));

  function automatic acc_t mul(
    input int                c,
    input logic [COMP_W-1:0] x
  );
    return acc_t'(c * int'(x));
  endfunction

  logic              accept;
  logic [DW-1:0]     pix;
  logic [COMP_W-1:0] comp [3];
  logic [1:0]        act_q;
  logic [1:0]        eff;
  acc_t              prod [9];

  assign accept  = s_axis_video_tvalid
                 & s_axis_video_tready;
  assign pix     = Sel ? Sel_RGB
                       : s_axis_video_tdata;
  assign comp[0] = pix[DW-1 -: COMP_W];
  assign comp[1] = pix[COMP_W-1:0];
  assign comp[2] = pix[2*COMP_W-1 -: COMP_W];

  // The SOF beat itself already uses the new matrix
  assign eff = s_axis_video_tuser
             ? norm_mode(mode) : act_q;

  always_comb begin
    for (int i = 0; i < 9; i++)
      prod[i] = (eff == MODE_709)
              ? mul(COEF_709[i], comp[i % 3])
              : mul(COEF_601[i], comp[i % 3]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      act_q <= MODE_601;
    else if (accept && s_axis_video_tuser)
      act_q <= norm_mode(mode);
  end

  assign active_mode = act_q;

  logic          s1_valid;
  logic          s1_byp;
  logic          s1_last;
  logic          s1_user;
  logic [DW-1:0] s1_pix;
  acc_t          s1_prod [9];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_byp   <= 1'b0;
      s1_last  <= 1'b0;
      s1_user  <= 1'b0;
      s1_pix   <= '0;
      for (int i = 0; i < 9; i++)
        s1_prod[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_byp  <= (eff == MODE_BYPASS);
        s1_last <= s_axis_video_tlast;
        s1_user <= s_axis_video_tuser;
        s1_pix  <= pix;
        for (int i = 0; i < 9; i++)
          s1_prod[i] <= prod[i];
      end
    end
  end

  acc_t              sy;
  acc_t              scb;
  acc_t              scr;
  acc_t              ty;
  acc_t              tcb;
  acc_t              tcr;
  logic [COMP_W-1:0] yc;
  logic [COMP_W-1:0] cbc;
  logic [COMP_W-1:0] crc;
  logic [DW-1:0]     cvt;

  assign sy  = s1_prod[0] + s1_prod[1]
             + s1_prod[2] + Y_OFS + RND;
  assign scb = s1_prod[3] + s1_prod[4]
             + s1_prod[5] + C_OFS + RND;
  assign scr = s1_prod[6] + s1_prod[7]
             + s1_prod[8] + C_OFS + RND;

  assign ty  = sy >>> COEF_FRAC;
  assign tcb = scb >>> COEF_FRAC;
  assign tcr = scr >>> COEF_FRAC;

  assign yc  = COMP_W'(clip(int'(ty), COMP_W));
  assign cbc = COMP_W'(clip(int'(tcb), COMP_W));
  assign crc = COMP_W'(clip(int'(tcr), COMP_W));
  assign cvt = {crc, cbc, yc};

  logic          s2_valid;
  logic [FW-1:0] s2_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_data  <= {s1_last, s1_user,
                   s1_byp ? s1_pix : cvt};
    end
  end

  logic          pop;
  logic [FW-1:0] fifo_out;
  logic [CW-1:0] fcount;

  assign pop = m_axis_video_tvalid
             & m_axis_video_tready;

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (s2_valid),
    .din   (s2_data),
    .pop   (pop),
    .dout  (fifo_out),
    .valid (m_axis_video_tvalid),
    .count (fcount)
  );

  assign {m_axis_video_tlast,
          m_axis_video_tuser,
          m_axis_video_tdata} = fifo_out;

  // Credit check: every beat in a stage will land in
  // the FIFO, so stages plus occupancy must fit in it
  logic [IW-1:0] infl_nxt;

  assign infl_nxt = IW'(accept) + IW'(s1_valid)
                  + IW'(s2_valid) + IW'(fcount)
                  - IW'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      s_axis_video_tready <= 1'b0;
    else
      s_axis_video_tready <=
        (infl_nxt < IW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_ycbcr_stream_conv.sv
// Scoreboard bench for ycbcr_stream_conv.
// Directed vectors, random traffic, backpressure, reset.
module tb_ycbcr_stream_conv;

  localparam int C  = 8;
  localparam int D  = 4;
  localparam int DW = 3 * C;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          Sel = 1'b0;
  logic [DW-1:0] Sel_RGB = '0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_tuser;
  logic [1:0]    active_mode;

  always #5 clk = ~clk;

  ycbcr_stream_conv #(
    .COMP_W     (C),
    .COEF_FRAC  (8),
    .FIFO_DEPTH (D)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .Sel                 (Sel),
    .Sel_RGB             (Sel_RGB),
    .mode                (mode),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tlast  (s_tlast),
    .s_axis_video_tuser  (s_tuser),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tlast  (m_tlast),
    .m_axis_video_tuser  (m_tuser),
    .active_mode         (active_mode)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          q [$];
  exp_t          mon_e;
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            last_acc = 0;
  logic [1:0]    tb_mode = 2'd0;
  bit            held = 0;
  logic [DW+1:0] held_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << C) - 1) return (1 << C) - 1;
    return v;
  endfunction

  // Reference: plain integer maths on the published matrices
  function automatic logic [DW-1:0] model(
    input logic [DW-1:0] p,
    input logic [1:0]    md
  );
    int r, g, b, y, cb, cr;
    r = int'(p[3*C-1:2*C]);
    b = int'(p[2*C-1:C]);
    g = int'(p[C-1:0]);
    if (md == 2'd2) return p;
    if (md == 2'd1) begin
      y  = 54*r + 183*g + 19*b;
      cb = -29*r - 99*g + 128*b;
      cr = 128*r - 116*g - 12*b;
    end else begin
      y  = 77*r + 150*g + 29*b;
      cb = -43*r - 85*g + 128*b;
      cr = 128*r - 107*g - 21*b;
    end
    y  = sat((y + (16 << C) + 128) >>> 8);
    cb = sat((cb + (1 << (C+7)) + 128) >>> 8);
    cr = sat((cr + (1 << (C+7)) + 128) >>> 8);
    return {C'(cr), C'(cb), C'(y)};
  endfunction

  // Called at posedge+1; returns at posedge+1
  task automatic send(
    input logic [DW-1:0] pix,
    input logic          s,
    input logic [DW-1:0] srgb,
    input logic          l,
    input logic          u,
    input logic [1:0]    md,
    input bit            use_model,
    input logic [DW-1:0] expd,
    input bit            lat
  );
    exp_t e;
    bit   ok;
    ok       = 0;
    s_tdata  = pix;
    Sel      = s;
    Sel_RGB  = srgb;
    s_tlast  = l;
    s_tuser  = u;
    mode     = md;
    s_tvalid = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      if (u) tb_mode = (md == 2'd3) ? 2'd0 : md;
      e.d   = use_model
            ? model(s ? srgb : pix, tb_mode) : expd;
      e.l   = l;
      e.u   = u;
      e.cyc = cyc;
      e.lat = lat;
      q.push_back(e);
      acc_cnt++;
      last_acc = cyc;
      @(posedge clk);
      #1;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: s_tready stuck low");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) break;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      held = 0;
    end else begin
      if (held) begin
        chk("stall_valid", 32'(m_tvalid), 1);
        chk("stall_hold",
            32'({m_tlast, m_tuser, m_tdata}),
            32'(held_v));
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %0h",
                   m_tdata);
        end else begin
          mon_e = q.pop_front();
          chk("tdata", 32'(m_tdata), 32'(mon_e.d));
          chk("tlast", 32'(m_tlast), 32'(mon_e.l));
          chk("tuser", 32'(m_tuser), 32'(mon_e.u));
          if (mon_e.lat)
            chk("latency", 32'(cyc),
                32'(mon_e.cyc + 3));
        end
      end
      held   = m_tvalid && !m_tready;
      held_v = {m_tlast, m_tuser, m_tdata};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int fa;

    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tdata", 32'(m_tdata), 0);
    chk("rst_m_side", 32'({m_tlast, m_tuser}), 0);
    chk("rst_active_mode", 32'(active_mode), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_release", 32'(s_tready), 1);

    // BT.601 known values
    send(24'h000000, 0, DW'($urandom), 0, 1, 2'd0,
         0, {8'd128, 8'd128, 8'd16}, 1);
    send(24'hFFFFFF, 0, DW'($urandom), 0, 0, 2'd0,
         0, {8'd128, 8'd128, 8'd255}, 1);
    send({8'd255, 8'd0, 8'd0}, 0, DW'($urandom), 1, 0,
         2'd0, 0, {8'd255, 8'd85, 8'd93}, 1);
    drain(50);
    chk("active_mode_601", 32'(active_mode), 0);

    // BT.709 pure green
    send({8'd0, 8'd0, 8'd255}, 0, '0, 0, 1, 2'd1,
         1, '0, 1);
    drain(50);
    chk("active_mode_709", 32'(active_mode), 1);

    // Mid-frame mode change is ignored until SOF
    send(DW'($urandom), 0, '0, 0, 1, 2'd0, 1, '0, 1);
    for (int i = 0; i < 3; i++)
      send(DW'($urandom), 0, '0, 0, 0, 2'd1, 1, '0, 1);
    chk("active_mode_midframe", 32'(active_mode), 0);
    send(DW'($urandom), 0, '0, 0, 1, 2'd1, 1, '0, 1);
    for (int i = 0; i < 2; i++)
      send(DW'($urandom), 0, '0, i == 1, 0, 2'd0,
           1, '0, 1);
    drain(50);
    chk("active_mode_new_frame", 32'(active_mode), 1);

    // Bypass
    send(24'h123456, 0, DW'($urandom), 1, 1, 2'd2,
         0, 24'h123456, 1);
    drain(50);
    chk("active_mode_bypass", 32'(active_mode), 2);

    // Random traffic with stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(DW'($urandom),
               1'($urandom_range(0, 1)),
               DW'($urandom),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0,
               2'($urandom_range(0, 3)),
               1, '0, 0);
        end
      end
      begin
        m_tready = 1'b0;
        a0 = acc_cnt;
        repeat (20) @(posedge clk);
        #2;
        chk("stall_fill_le_depth",
            32'((acc_cnt - a0) <= D), 1);
        chk("stall_tready_low", 32'(s_tready), 0);
        for (int i = 0; i < 150; i++) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1'b1;
      end
    join
    drain(1000);

    // Throughput with sustained ready
    m_tready = 1'b1;
    send(DW'($urandom), 0, '0, 0, 1, 2'd0, 1, '0, 0);
    fa = last_acc;
    for (int i = 0; i < 31; i++)
      send(DW'($urandom), 0, '0, 0, 0,
           2'($urandom_range(0, 3)), 1, '0, 0);
    chk("throughput_cycles", 32'(last_acc - fa), 31);
    drain(100);

    // Reset with beats in flight
    m_tready = 1'b0;
    send(DW'($urandom), 0, '0, 0, 1, 2'd0, 1, '0, 0);
    send(DW'($urandom), 0, '0, 0, 0, 2'd0, 1, '0, 0);
    send(DW'($urandom), 0, '0, 0, 0, 2'd0, 1, '0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(m_tvalid), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 32'(m_tvalid), 0);
    chk("mid_rst_m_tdata", 32'(m_tdata), 0);
    chk("mid_rst_s_tready", 32'(s_tready), 0);
    chk("mid_rst_active_mode", 32'(active_mode), 0);
    q.delete();
    tb_mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rerelease", 32'(s_tready), 1);
    m_tready = 1'b1;
    send(24'h0A0B0C, 0, '0, 0, 1, 2'd2,
         0, 24'h0A0B0C, 1);
    send(24'h0D0E0F, 0, '0, 1, 0, 2'd0,
         0, 24'h0D0E0F, 1);
    drain(50);
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
